// File: rtl/rename_table.sv
// Register alias table plus architectural register file for the dispatch stage.
// Optional feature: define RENAME_RETIRE_BYPASS_EN to forward retiring data to same-cycle lookups.
module rename_table #(
   parameter int N_ARF        = 32,
   parameter int ARF_ID_WIDTH = 5,
   parameter int ROB_ID_WIDTH = 3,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dispatch_fire,
   input  logic                    dispatch_dst_valid,
   input  logic [ARF_ID_WIDTH-1:0] dispatch_dst_arf_id,
   input  logic [ROB_ID_WIDTH-1:0] dispatch_rob_id,
   input  logic [ARF_ID_WIDTH-1:0] src1_arf_id,
   input  logic [ARF_ID_WIDTH-1:0] src2_arf_id,
   output logic                    src1_renamed,
   output logic                    src2_renamed,
   output logic [ROB_ID_WIDTH-1:0] src1_rob_id,
   output logic [ROB_ID_WIDTH-1:0] src2_rob_id,
   output logic [DATA_WIDTH-1:0]   src1_arf_data,
   output logic [DATA_WIDTH-1:0]   src2_arf_data,
   input  logic                    retire,
   input  logic [ROB_ID_WIDTH-1:0] retire_rob_id,
   input  logic [ARF_ID_WIDTH-1:0] retire_arf_id,
   input  logic [DATA_WIDTH-1:0]   retire_reg_data,
   input  logic                    flush,
   output logic [ARF_ID_WIDTH:0]   renamed_count
);

   localparam logic [ARF_ID_WIDTH:0] CNT_ONE = 1;

   typedef struct packed {
      logic                    renamed;
      logic [ROB_ID_WIDTH-1:0] rob_id;
      logic [DATA_WIDTH-1:0]   data;
   } lookup_t;

   logic                    valid_q    [N_ARF];
   logic [ROB_ID_WIDTH-1:0] rob_id_q   [N_ARF];
   logic [DATA_WIDTH-1:0]   arf_data_q [N_ARF];
   logic [ARF_ID_WIDTH:0]   renamed_count_q;
   logic [ARF_ID_WIDTH:0]   count_next;

   logic    retire_commit;
   logic    retire_hit;
   logic    dispatch_write;
   logic    count_inc;
   logic    count_dec;
   lookup_t src1_res;
   lookup_t src2_res;

   assign retire_commit  = retire && (retire_arf_id != '0);
   assign retire_hit     = retire_commit && valid_q[retire_arf_id]
                           && (rob_id_q[retire_arf_id] == retire_rob_id);
   assign dispatch_write = dispatch_fire && dispatch_dst_valid
                           && (dispatch_dst_arf_id != '0) && !flush;

   // Lookups always see pre-update state; x0 is forced to a committed zero.
   function automatic lookup_t lookup(input logic [ARF_ID_WIDTH-1:0] id);
      lookup_t res;
      res = '0;
      if (id != '0) begin
         res.renamed = valid_q[id];
         res.rob_id  = rob_id_q[id];
         res.data    = arf_data_q[id];
`ifdef RENAME_RETIRE_BYPASS_EN
         if (retire_hit && (id == retire_arf_id)) begin
            res.renamed = 1'b0;
            res.data    = retire_reg_data;
         end
`endif
      end
      return res;
   endfunction

   assign src1_res      = lookup(src1_arf_id);
   assign src2_res      = lookup(src2_arf_id);
   assign src1_renamed  = src1_res.renamed;
   assign src1_rob_id   = src1_res.rob_id;
   assign src1_arf_data = src1_res.data;
   assign src2_renamed  = src2_res.renamed;
   assign src2_rob_id   = src2_res.rob_id;
   assign src2_arf_data = src2_res.data;
   assign renamed_count = renamed_count_q;

   // A retire clearing a register that dispatch re-maps this cycle leaves the count unchanged.
   assign count_inc = dispatch_write && !valid_q[dispatch_dst_arf_id];
   assign count_dec = retire_hit
                      && !(dispatch_write && (dispatch_dst_arf_id == retire_arf_id));

   always_comb begin
      count_next = renamed_count_q;
      if (flush) begin
         count_next = '0;
      end else if (count_inc && !count_dec) begin
         count_next = renamed_count_q + CNT_ONE;
      end else if (count_dec && !count_inc) begin
         count_next = renamed_count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ARF; i++) begin
            valid_q[i]    <= 1'b0;
            rob_id_q[i]   <= '0;
            arf_data_q[i] <= '0;
         end
         renamed_count_q <= '0;
      end else begin
         if (retire_commit) begin
            arf_data_q[retire_arf_id] <= retire_reg_data;
         end
         if (flush) begin
            for (int i = 0; i < N_ARF; i++) begin
               valid_q[i] <= 1'b0;
            end
         end else begin
            // Dispatch is written after retire so the younger mapping wins on the same register.
            if (retire_hit) begin
               valid_q[retire_arf_id] <= 1'b0;
            end
            if (dispatch_write) begin
               valid_q[dispatch_dst_arf_id]  <= 1'b1;
               rob_id_q[dispatch_dst_arf_id] <= dispatch_rob_id;
            end
         end
         renamed_count_q <= count_next;
      end
   end

endmodule
